// File: rtl/shape_mask_collector_pkg.sv
// Shared types for shape_mask_collector: FSM state, pixel coordinate, shape index.
`ifndef INT_BITS
`define INT_BITS 8
`endif

package shape_mask_collector_pkg;
  localparam int PIX_W = 12;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
  } pix_t;

  typedef logic [`INT_BITS-1:0] shp_idx_t;
endpackage

// File: rtl/shape_mask_collector_stepper.sv
// Shape index counter: clamped shape count, last-index flag, latched enables and
// (with SHAPE_SKIP_EN) a skip flag for disabled shapes.
module shape_mask_collector_stepper
  import shape_mask_collector_pkg::*;
#(
  parameter int MAXSHP = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  shp_idx_t          shape_count,
  input  logic [MAXSHP-1:0] shape_enable,
  output shp_idx_t          idx,
  output logic              n_zero,
  output logic              last,
  output logic              cur_en,
  output logic              skip
);
  shp_idx_t          n_clamp, last_idx;
  logic [MAXSHP-1:0] en_q;

  assign n_clamp = (shape_count > shp_idx_t'(MAXSHP)) ? shp_idx_t'(MAXSHP) : shape_count;
  assign n_zero  = (n_clamp == '0);

  // last_idx is only consulted when n>0, so the n==0 wrap is harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      last_idx <= '0;
      en_q     <= '0;
    end else if (load) begin
      idx      <= '0;
      last_idx <= n_clamp - 1'b1;
      en_q     <= shape_enable;
    end else if (step) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == last_idx);

  always_comb begin
    cur_en = 1'b0;
    for (int k = 0; k < MAXSHP; k++)
      if (idx == shp_idx_t'(k)) cur_en = en_q[k];
  end

`ifdef SHAPE_SKIP_EN
  assign skip = ~cur_en;
`else
  assign skip = 1'b0;
`endif
endmodule

// File: rtl/shape_mask_collector.sv
// Per-pixel shape coverage mask builder; queries the hit-test unit once per shape.
// Optional SHAPE_SKIP_EN: disabled shapes are stepped over without a query.
module shape_mask_collector
  import shape_mask_collector_pkg::*;
#(
  parameter int PIXLW  = PIX_W,
  parameter int MAXSHP = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [PIXLW-1:0]  px_x,
  input  logic [PIXLW-1:0]  px_y,
  input  shp_idx_t          shape_count,
  input  logic [MAXSHP-1:0] shape_enable,
  output logic              q_valid,
  input  logic              q_ready,
  output shp_idx_t          q_id,
  output logic [PIXLW-1:0]  q_x,
  output logic [PIXLW-1:0]  q_y,
  input  logic              r_valid,
  input  logic              r_hit,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic [MAXSHP-1:0] mask,
  output logic [PIXLW-1:0]  mask_x,
  output logic [PIXLW-1:0]  mask_y
);
  state_t            state, nstate;
  logic              ld, step, acc_wr;
  logic              n_zero, last, cur_en, skip;
  shp_idx_t          idx;
  logic [PIXLW-1:0]  x_q, y_q;
  logic [MAXSHP-1:0] acc;

  shape_mask_collector_stepper #(.MAXSHP(MAXSHP)) u_step (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (ld),
    .step         (step),
    .shape_count  (shape_count),
    .shape_enable (shape_enable),
    .idx          (idx),
    .n_zero       (n_zero),
    .last         (last),
    .cur_en       (cur_en),
    .skip         (skip)
  );

  always_comb begin
    nstate     = state;
    px_ready   = 1'b0;
    q_valid    = 1'b0;
    mask_valid = 1'b0;
    ld         = 1'b0;
    step       = 1'b0;
    acc_wr     = 1'b0;
    unique case (state)
      IDLE: begin
        px_ready = 1'b1;
        if (px_valid) begin
          ld     = 1'b1;
          nstate = n_zero ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (skip) begin
          // disabled shape: its accumulator bit stays at the cleared 0
          if (last) nstate = DONE;
          else      step   = 1'b1;
        end else begin
          q_valid = 1'b1;
          if (q_ready) nstate = WAIT;
        end
      end
      WAIT: begin
        if (r_valid) begin
          acc_wr = 1'b1;
          if (last) nstate = DONE;
          else begin
            step   = 1'b1;
            nstate = ISSUE;
          end
        end
      end
      DONE: begin
        mask_valid = 1'b1;
        if (mask_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      acc   <= '0;
    end else begin
      state <= nstate;
      if (ld) begin
        x_q <= px_x;
        y_q <= px_y;
        acc <= '0;
      end else if (acc_wr) begin
        for (int k = 0; k < MAXSHP; k++)
          if (idx == shp_idx_t'(k)) acc[k] <= r_hit & cur_en;
      end
    end
  end

  assign q_id   = idx;
  assign q_x    = x_q;
  assign q_y    = y_q;
  assign mask   = acc;
  assign mask_x = x_q;
  assign mask_y = y_q;
endmodule

// File: tb/tb_shape_mask_collector.sv
// Bench for shape_mask_collector: directed table, stall/reset sequences, random pixels.
`ifndef INT_BITS
`define INT_BITS 8
`endif

module tb_shape_mask_collector;
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 px_valid, px_ready;
  logic [11:0]          px_x, px_y;
  logic [`INT_BITS-1:0] shape_count;
  logic [15:0]          shape_enable;
  logic                 q_valid, q_ready;
  logic [`INT_BITS-1:0] q_id;
  logic [11:0]          q_x, q_y;
  logic                 r_valid, r_hit;
  logic                 mask_valid, mask_ready;
  logic [15:0]          mask;
  logic [11:0]          mask_x, mask_y;

  shape_mask_collector #(.PIXLW(12), .MAXSHP(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .shape_count(shape_count), .shape_enable(shape_enable),
    .q_valid(q_valid), .q_ready(q_ready), .q_id(q_id), .q_x(q_x), .q_y(q_y),
    .r_valid(r_valid), .r_hit(r_hit),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask(mask), .mask_x(mask_x), .mask_y(mask_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // hit-test unit model and query logger
  logic [15:0]          hit_vec;
  bit                   rnd_mode;
  int                   stall_left;
  logic [11:0]          cur_x, cur_y;
  int                   qlog[$];
  bit                   pend, prev_stall;
  int                   pend_dly;
  logic                 pend_hit;
  logic [`INT_BITS-1:0] prev_id;

  initial begin
    r_valid = 0; r_hit = 0; q_ready = 1; pend = 0; prev_stall = 0; pend_dly = 0;
    pend_hit = 0; prev_id = '0;
    forever begin
      @(negedge clk);
      r_valid = 0;
      r_hit   = 1'($urandom);
      if (!rst_n) begin
        pend = 0; prev_stall = 0; q_ready = 1;
      end else begin
        if (pend) begin
          if (pend_dly == 0) begin
            r_valid = 1; r_hit = pend_hit; pend = 0;
          end else pend_dly--;
        end else if (rnd_mode && $urandom_range(4) == 0) begin
          r_valid = 1;  // stray result outside WAIT, must be ignored
        end
        if (stall_left > 0) q_ready = 0;
        else if (rnd_mode)  q_ready = ($urandom_range(3) != 0);
        else                q_ready = 1;
        if (q_valid) begin
          chk("q_x", 32'(q_x), 32'(cur_x));
          chk("q_y", 32'(q_y), 32'(cur_y));
          if (prev_stall) chk("q_id_hold", 32'(q_id), 32'(prev_id));
          if (stall_left > 0) stall_left--;
          if (q_ready) begin
            qlog.push_back(int'(q_id));
            pend       = 1;
            pend_dly   = rnd_mode ? int'($urandom_range(2)) : 0;
            pend_hit   = (q_id < 16) ? hit_vec[q_id[3:0]] : 1'b0;
            prev_stall = 0;
          end else begin
            prev_stall = 1; prev_id = q_id;
          end
        end else prev_stall = 0;
      end
    end
  end

  // Drives one pixel, checks the mask against the spec model, returns observations.
  task automatic run_pixel(input logic [11:0] x, input logic [11:0] y,
                           input logic [`INT_BITS-1:0] cnt, input logic [15:0] en,
                           input logic [15:0] hits, input int mstall,
                           output int lat, output int nq, output logic [15:0] m);
    int n, guard;
    logic [15:0] emask;
    int expq[$];
    lat = -1; nq = -1; m = 'x;
    n = (int'(cnt) > 16) ? 16 : int'(cnt);
    emask = '0;
    for (int i = 0; i < n; i++) begin
      emask[i] = hits[i] & en[i];
`ifdef SHAPE_SKIP_EN
      if (en[i]) expq.push_back(i);
`else
      expq.push_back(i);
`endif
    end
    guard = 0;
    while (!px_ready && guard < 400) begin @(negedge clk); guard++; end
    if (!px_ready) begin chk("px_ready_wait", 32'(px_ready), 1); return; end
    hit_vec = hits; cur_x = x; cur_y = y; qlog.delete();
    px_valid = 1; px_x = x; px_y = y; shape_count = cnt; shape_enable = en;
    @(negedge clk);
    px_valid = 0;
    px_x = 12'($urandom); px_y = 12'($urandom);
    shape_count = `INT_BITS'($urandom); shape_enable = 16'($urandom);
    chk("px_ready_busy", 32'(px_ready), 0);
    lat = 1;
    while (!mask_valid && lat < 400) begin @(negedge clk); lat++; end
    if (!mask_valid) begin chk("mask_valid_wait", 32'(mask_valid), 1); lat = -1; return; end
    m = mask;
    chk("mask", 32'(mask), 32'(emask));
    chk("mask_x", 32'(mask_x), 32'(x));
    chk("mask_y", 32'(mask_y), 32'(y));
    for (int s = 0; s < mstall; s++) begin
      mask_ready = 0;
      @(negedge clk);
      chk("hold_valid", 32'(mask_valid), 1);
      chk("hold_mask", 32'(mask), 32'(emask));
      chk("hold_mask_x", 32'(mask_x), 32'(x));
      chk("hold_px_ready", 32'(px_ready), 0);
    end
    mask_ready = 1;
    @(negedge clk);
    mask_ready = 0;
    chk("post_valid", 32'(mask_valid), 0);
    chk("post_px_ready", 32'(px_ready), 1);
    nq = qlog.size();
    chk("q_count", 32'(qlog.size()), 32'(expq.size()));
    for (int i = 0; i < qlog.size() && i < expq.size(); i++)
      chk("q_id_seq", 32'(qlog[i]), 32'(expq[i]));
  endtask

  typedef struct {
    logic [11:0]          x, y;
    logic [`INT_BITS-1:0] cnt;
    logic [15:0]          en, hits, m;
    int                   lat, nq;
  } vec_t;

  function automatic vec_t mk(input int x, input int y, input int cnt, input logic [15:0] en,
                              input logic [15:0] hits, input logic [15:0] m,
                              input int lat, input int nq);
    vec_t v;
    v.x = x[11:0]; v.y = y[11:0]; v.cnt = cnt[`INT_BITS-1:0];
    v.en = en; v.hits = hits; v.m = m; v.lat = lat; v.nq = nq;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, nq;
    logic [15:0] m;
    rst_n = 0; px_valid = 0; px_x = 0; px_y = 0; shape_count = 0; shape_enable = 0;
    mask_ready = 0; hit_vec = 0; rnd_mode = 0; stall_left = 0; cur_x = 0; cur_y = 0;

    tbl[0] = mk(10, 20, 3, 16'hFFFF, 16'h0005, 16'h0005, 7, 3);
    tbl[1] = mk(100, 200, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0);
    tbl[2] = mk(5, 6, 20, 16'hFFFF, 16'hFFFF, 16'hFFFF, 33, 16);
`ifdef SHAPE_SKIP_EN
    tbl[3] = mk(7, 8, 4, 16'h0002, 16'hFFFF, 16'h0002, 6, 1);
    tbl[4] = mk(4095, 4095, 16, 16'hA5A5, 16'hFFFF, 16'hA5A5, 25, 8);
`else
    tbl[3] = mk(7, 8, 4, 16'h0002, 16'hFFFF, 16'h0002, 9, 4);
    tbl[4] = mk(4095, 4095, 16, 16'hA5A5, 16'hFFFF, 16'hA5A5, 33, 16);
`endif
    tbl[5] = mk(1, 2, 1, 16'h0001, 16'h0000, 16'h0000, 3, 1);
    tbl[6] = mk(0, 4095, 5, 16'hFFFF, 16'h5555, 16'h0015, 11, 5);

    repeat (2) @(negedge clk);
    chk("rst_px_ready", 32'(px_ready), 1);
    chk("rst_q_valid", 32'(q_valid), 0);
    chk("rst_mask_valid", 32'(mask_valid), 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_q_id", 32'(q_id), 0);
    chk("idle_q_x", 32'(q_x), 0);
    chk("idle_mask", 32'(mask), 0);
    chk("idle_mask_y", 32'(mask_y), 0);

    for (int i = 0; i < 7; i++) begin
      run_pixel(tbl[i].x, tbl[i].y, tbl[i].cnt, tbl[i].en, tbl[i].hits, 0, lat, nq, m);
      chk($sformatf("tbl%0d_mask", i), 32'(m), 32'(tbl[i].m));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_nq", i), 32'(nq), 32'(tbl[i].nq));
    end

    // query stalled 5 cycles, then mask held 3 cycles
    stall_left = 5;
    run_pixel(12'd321, 12'd654, 2, 16'hFFFF, 16'h0003, 3, lat, nq, m);
    chk("stall_lat", 32'(lat), 10);
    chk("stall_left_used", 32'(stall_left), 0);

    // reset during WAIT; the result arrives after reset and must be dropped
    hit_vec = 16'hFFFF; cur_x = 12'd33; cur_y = 12'd44; qlog.delete();
    px_valid = 1; px_x = 12'd33; px_y = 12'd44; shape_count = 3; shape_enable = 16'hFFFF;
    @(negedge clk);
    px_valid = 0;
    chk("abort_q_valid_pre", 32'(q_valid), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_px_ready", 32'(px_ready), 1);
    chk("abort_q_valid", 32'(q_valid), 0);
    chk("abort_mask_valid", 32'(mask_valid), 0);
    chk("abort_q_id", 32'(q_id), 0);
    chk("abort_q_x", 32'(q_x), 0);
    chk("abort_q_y", 32'(q_y), 0);
    chk("abort_mask", 32'(mask), 0);
    chk("abort_mask_x", 32'(mask_x), 0);
    chk("abort_mask_y", 32'(mask_y), 0);
    #1 rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    chk("late_r_mask", 32'(mask), 0);
    chk("late_r_state", 32'(px_ready), 1);
    run_pixel(12'd9, 12'd9, 1, 16'h0001, 16'h0000, 0, lat, nq, m);
    chk("late_r_next_mask", 32'(m), 0);

    // random pixels with random handshakes, delays and stray results
    rnd_mode = 1;
    for (int t = 0; t < 40; t++) begin
      run_pixel(12'($urandom), 12'($urandom), `INT_BITS'($urandom_range(20)),
                16'($urandom), 16'($urandom), int'($urandom_range(2)), lat, nq, m);
    end
    rnd_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shape_mask_collector.md
Name: shape_mask_collector

Overview:
- Producer side of the per-shape coverage mask consumed by the pixel selection stage.
- For each requested pixel coordinate, queries a shared point-in-shape hit-test unit once per shape, sequentially.
- Accumulates the hit bits into an MAXSHP-wide mask and hands the mask downstream over a valid/ready handshake.
- Sits between the raster scan generator and the pixel selector.

Parameters:
- PIXLW, 12, width of each pixel coordinate (x and y).
- MAXSHP, 16, number of shape slots; the mask width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- px_valid  in  1  pixel request valid
- px_ready  out  1  collector can accept a pixel
- px_x  in  PIXLW  pixel x
- px_y  in  PIXLW  pixel y
- shape_count  in  `INT_BITS  number of live shapes; sampled at pixel accept
- shape_enable  in  MAXSHP  per-shape visibility; sampled at pixel accept
- q_valid  out  1  hit-test query valid
- q_ready  in  1  hit-test unit accepts query
- q_id  out  `INT_BITS  shape index being queried
- q_x, q_y  out  PIXLW each  registered pixel coordinate
- r_valid  in  1  hit-test result valid (one per accepted query, in order)
- r_hit  in  1  pixel inside shape q_id
- mask_valid  out  1  mask available
- mask_ready  in  1  downstream accepts mask
- mask  out  MAXSHP  bit i set = pixel covered by shape i
- mask_x, mask_y  out  PIXLW each  coordinate matching mask

Behaviour:
- Reset: state IDLE; px_ready=1; q_valid=0; mask_valid=0; q_id, q_x, q_y, mask, mask_x, mask_y = 0.
- Clock and reset: one clock; reset is asynchronous and active-low.
- IDLE (px_ready=1): on px_valid, latch x, y, enable and n = min(shape_count, MAXSHP); clear the accumulator; set i=0.
  - If n==0, go to DONE next cycle with mask=0.
  - Otherwise go to ISSUE.
- ISSUE: q_valid=1, q_id=i.
  - On q_ready, drop q_valid and go to WAIT.
  - q_id, q_x and q_y are held stable while q_valid=1 and q_ready=0.
- WAIT: on r_valid, acc[i] <= r_hit & enable[i].
  - If i==n-1, go to DONE; else i<=i+1 and return to ISSUE.
  - r_valid outside WAIT is ignored.
- DONE: mask_valid=1; mask, mask_x and mask_y are stable until mask_ready.
  - On mask_ready, go to IDLE (px_ready=1 the following cycle).
  - There is no same-cycle pass-through from DONE to accept a new pixel.
- Latency with a 1-cycle hit-test: px accept to mask_valid = 2n+1 cycles for n>0; 1 cycle for n==0.
- Mask bits at index >= n are always 0.
- shape_count > MAXSHP is clamped to MAXSHP.
- Index counter width is `INT_BITS.
  - The last-shape compare uses n-1 computed at accept, so no wrap occurs when n==MAXSHP.
- Changes on shape_count, shape_enable, px_x or px_y after accept do not affect the in-flight pixel.
- Reset mid-operation aborts immediately: outstanding results are discarded and all outputs return to reset values.

Optional Feature:
- Macro SHAPE_SKIP_EN.
- Defined: in ISSUE, shapes with the latched enable[i]==0 are not queried.
  - The counter advances one index per cycle, with acc[i]=0, until it reaches an enabled index or passes n-1 (then DONE).
  - If all shapes are disabled, DONE is reached without any query.
- Not defined: every index 0..n-1 is queried and disabled bits are masked by the AND.
- Resulting mask and coordinates are identical either way; only timing and the number of queries differ.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - a pixel coordinate struct {x, y} of PIXLW bits;
  - the `INT_BITS-based shape index typedef.
- A sub-module is natural: shape_index_stepper. It holds the index counter, the clamped n, the last-index flag and, under SHAPE_SKIP_EN, the next-enabled search.

Test Plan:
- Reset, then MAXSHP=16, shape_count=3, enable=16'hFFFF, hits 1,0,1 with 1-cycle response → q_id sequence 0,1,2; mask=16'h0005; mask_valid exactly 7 cycles after px accept.
- shape_count=0, px_valid at (100,200) → no q_valid; mask_valid after 1 cycle with mask=0, mask_x=100, mask_y=200.
- shape_count=20, all hits=1, enable=16'hFFFF → 16 queries (q_id 0..15); mask=16'hFFFF; no query for index 16+.
- enable=16'h0002, shape_count=4, all hits=1 → mask=16'h0002.
  - With SHAPE_SKIP_EN: a single query, q_id=1.
  - Without SHAPE_SKIP_EN: 4 queries.
- q_ready held low for 5 cycles in ISSUE, then mask_ready held low 3 cycles in DONE → q_id, q_x, q_y, mask and mask_x stable throughout; px_ready=0 until one cycle after the mask handshake.
- rst_n asserted mid-WAIT with r_valid arriving the next cycle → all outputs at reset values; the late result does not alter the next pixel's mask.
